// File: rtl/load_data_align_pkg.sv
// Shared constants and state encoding for the load data align stage.
package load_data_align_pkg;

   localparam int DATA_READ_WIDTH = 32;
   localparam int ELEM_WIDTH      = 16;
   localparam int OUT_ELEMS       = 32;
   localparam int IDX_W           = 11;

   // One extra bit so begin+len and fill+len never wrap.
   typedef logic [IDX_W:0] ext_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PART,
      ST_OUT
   } state_e;

endpackage

// File: rtl/load_data_align_slice_shift.sv
// Extracts word[begin +: len] and places it at element offset dest of an
// OUT_ELEMS-wide zero-filled vector, reporting clamping/overflow.
module load_slice_shift
   import load_data_align_pkg::*;
#(
   parameter int DRW = DATA_READ_WIDTH,
   parameter int EW  = ELEM_WIDTH,
   parameter int OE  = OUT_ELEMS
) (
   input  logic [DRW*EW-1:0] word_i,
   input  logic [IDX_W-1:0]  begin_i,
   input  logic [IDX_W-1:0]  len_i,
   input  logic [IDX_W-1:0]  dest_i,
   output logic [OE*EW-1:0]  vec_o,
   output logic [IDX_W-1:0]  end_o,
   output logic              ovf_o
);

   logic [EW-1:0] elems [DRW];
   ext_t endW;
   ext_t srcLen;
   ext_t placeEnd;
   ext_t pos;
   ext_t src;
   logic clampErr;
   logic posErr;

   for (genvar s = 0; s < DRW; s++) begin : g_elems
      assign elems[s] = word_i[s*EW +: EW];
   end

   always_comb begin
      endW     = {1'b0, begin_i} + {1'b0, len_i};
      clampErr = endW > ext_t'(DRW);
      srcLen   = {1'b0, len_i};
      if (clampErr) begin
         srcLen = ({1'b0, begin_i} >= ext_t'(DRW)) ? '0 : ext_t'(DRW) - {1'b0, begin_i};
      end
      placeEnd = {1'b0, dest_i} + srcLen;
      posErr   = placeEnd > ext_t'(OE);
      ovf_o    = clampErr || posErr;
      end_o    = posErr ? IDX_W'(OE) : placeEnd[IDX_W-1:0];
   end

   // Positions at or beyond OE simply do not exist, which drops the excess.
   always_comb begin
      vec_o = '0;
      pos   = '0;
      src   = '0;
      for (int p = 0; p < OE; p++) begin
         pos = ext_t'(p);
         if (pos >= {1'b0, dest_i} && pos < placeEnd) begin
            src = {1'b0, begin_i} + (pos - {1'b0, dest_i});
            for (int s = 0; s < DRW; s++) begin
               if (src == ext_t'(s)) begin
                  vec_o[p*EW +: EW] = elems[s];
               end
            end
         end
      end
   end

endmodule

// File: rtl/load_data_align.sv
// Packs one or two buffer read beats into a zero-padded element vector
// and hands it to the PE feed over valid/ready.
module load_data_align
   import load_data_align_pkg::*;
#(
   parameter int DRW = DATA_READ_WIDTH,
   parameter int EW  = ELEM_WIDTH,
   parameter int OE  = OUT_ELEMS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DRW*EW-1:0] in_word,
   input  logic [IDX_W-1:0]  in_begin,
   input  logic [IDX_W-1:0]  in_len,
   input  logic              in_first,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OE*EW-1:0]  out_data,
   output logic [IDX_W-1:0]  out_len,
   output logic              err
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] fill_q, fill_d;
   logic [IDX_W-1:0] outLen_q, outLen_d;
   logic [OE*EW-1:0] data_q, data_d;
   logic             err_q, err_d;

   logic [IDX_W-1:0] dest;
   logic [OE*EW-1:0] sliceVec;
   logic [IDX_W-1:0] sliceEnd;
   logic             sliceOvf;
   logic             accept;
   logic             fire;

   // Only a final beat arriving in PART appends behind the held half.
   assign dest = (state_q == ST_PART && !in_first) ? fill_q : '0;

   load_slice_shift #(.DRW(DRW), .EW(EW), .OE(OE)) u_slice (
      .word_i (in_word),
      .begin_i(in_begin),
      .len_i  (in_len),
      .dest_i (dest),
      .vec_o  (sliceVec),
      .end_o  (sliceEnd),
      .ovf_o  (sliceOvf)
   );

   assign in_ready  = (state_q != ST_OUT) || out_ready;
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = data_q;
   assign out_len   = outLen_q;
   assign err       = err_q;
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      outLen_d = outLen_q;
      data_d   = data_q;
      err_d    = err_q;
      if (fire) begin
         state_d = ST_IDLE;
      end
      if (accept) begin
         err_d = err_q || sliceOvf;
         if (in_first) begin
            if (state_q == ST_PART) begin
               err_d = 1'b1;
            end
            data_d  = sliceVec;
            fill_d  = sliceEnd;
            state_d = ST_PART;
         end else begin
            // The first half zeroed everything above fill, so OR-merge is safe.
            data_d   = (state_q == ST_PART) ? (data_q | sliceVec) : sliceVec;
            outLen_d = sliceEnd;
            fill_d   = '0;
            state_d  = ST_OUT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         fill_q   <= '0;
         outLen_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         outLen_q <= outLen_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_load_data_align.sv
// Drives directed and random beats into load_data_align and compares every
// cycle against an element-queue model of the packing rules.
module tb_load_data_align;
   import load_data_align_pkg::*;

   localparam int DRW = DATA_READ_WIDTH;
   localparam int EW  = ELEM_WIDTH;
   localparam int OE  = OUT_ELEMS;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DRW*EW-1:0] in_word;
   logic [IDX_W-1:0]  in_begin;
   logic [IDX_W-1:0]  in_len;
   logic              in_first;
   logic              out_valid;
   logic              out_ready;
   logic [OE*EW-1:0]  out_data;
   logic [IDX_W-1:0]  out_len;
   logic              err;

   int vectors     = 0;
   int miscompares = 0;

   // Model: held first half, pending output vector, sticky error.
   int heldQ[$];
   int outQ[$];
   bit mPend;
   bit mPart;
   bit mErr;

   load_data_align dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .in_begin(in_begin), .in_len(in_len), .in_first(in_first),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_len(out_len), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [EW-1:0] elemOf(int i);
      return out_data[i*EW +: EW];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkVec(input string name, input logic [OE*EW-1:0] act, input logic [OE*EW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearModel();
      heldQ.delete();
      outQ.delete();
      mPend = 1'b0;
      mPart = 1'b0;
      mErr  = 1'b0;
   endtask

   task automatic checkOutput();
      logic [OE*EW-1:0] expVec;
      check("out_valid", out_valid, mPend);
      check("in_ready", in_ready, !mPend || out_ready);
      check("err", err, mErr);
      if (mPend) begin
         expVec = '0;
         foreach (outQ[e]) expVec[e*EW +: EW] = EW'(outQ[e]);
         check("out_len", out_len, outQ.size());
         checkVec("out_data", out_data, expVec);
      end
   endtask

   task automatic modelStep();
      int  sl[$];
      int  endIdx;
      bit  acc;
      acc = in_valid && (!mPend || out_ready);
      if (mPend && out_ready) mPend = 1'b0;
      if (acc) begin
         endIdx = int'(in_begin) + int'(in_len);
         if (endIdx > DRW) mErr = 1'b1;
         for (int idx = int'(in_begin); idx < endIdx && idx < DRW; idx++)
            sl.push_back(int'(in_word[idx*EW +: EW]));
         if (in_first) begin
            if (mPart) mErr = 1'b1;
            heldQ = sl;
            mPart = 1'b1;
         end else begin
            outQ.delete();
            if (mPart) outQ = heldQ;
            foreach (sl[k]) outQ.push_back(sl[k]);
            if (outQ.size() > OE) mErr = 1'b1;
            while (outQ.size() > OE) void'(outQ.pop_back());
            heldQ.delete();
            mPend = 1'b1;
            mPart = 1'b0;
         end
      end
   endtask

   // base < 0 fills the word with random elements, else element i = base+i.
   task automatic applyStimulus(input bit v, input int base, input int b, input int l,
                                input bit f, input bit r);
      @(negedge clk);
      in_valid  = v;
      in_begin  = IDX_W'(b);
      in_len    = IDX_W'(l);
      in_first  = f;
      out_ready = r;
      for (int i = 0; i < DRW; i++)
         in_word[i*EW +: EW] = (base < 0) ? EW'($urandom) : EW'(base + i);
      #1;
      checkOutput();
      modelStep();
   endtask

   task automatic doReset();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      clearModel();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_len", out_len, 0);
      check("rst_err", err, 0);
      checkVec("rst_out_data", out_data, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_word = '0; in_begin = '0; in_len = '0;
      in_first = 1'b0; out_ready = 1'b0;
      clearModel();
      doReset();

      // Single beat.
      applyStimulus(1, 0, 4, 8, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("single_valid", out_valid, 1);
      check("single_len", out_len, 8);
      check("single_e0", elemOf(0), 4);
      check("single_e7", elemOf(7), 11);
      check("single_e8", elemOf(8), 0);

      // Split read, then backpressure with a waiting final beat.
      doReset();
      applyStimulus(1, 0, 28, 4, 1, 1);
      applyStimulus(1, 100, 0, 6, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("split_len", out_len, 10);
      check("split_e0", elemOf(0), 28);
      check("split_e3", elemOf(3), 31);
      check("split_e4", elemOf(4), 100);
      check("split_e9", elemOf(9), 105);
      check("split_e10", elemOf(10), 0);
      check("split_err", err, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 200, 0, 2, 0, 0);
         check("bp_in_ready", in_ready, 0);
         check("bp_len", out_len, 10);
      end
      applyStimulus(1, 200, 0, 2, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("bp_next_valid", out_valid, 1);
      check("bp_next_len", out_len, 2);
      check("bp_next_e1", elemOf(1), 201);

      // Two first halves in a row.
      doReset();
      applyStimulus(1, 0, 0, 3, 1, 1);
      applyStimulus(1, 50, 0, 5, 1, 1);
      applyStimulus(1, 90, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("proto_err", err, 1);
      check("proto_len", out_len, 6);
      check("proto_e0", elemOf(0), 50);
      check("proto_e5", elemOf(5), 90);

      // Slice past word end, then packed overflow.
      doReset();
      applyStimulus(1, 0, 30, 4, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("clamp_err", err, 1);
      check("clamp_len", out_len, 2);
      check("clamp_e1", elemOf(1), 31);
      doReset();
      applyStimulus(1, 0, 0, 20, 1, 1);
      applyStimulus(1, 100, 0, 20, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("ovf_len", out_len, 32);
      check("ovf_err", err, 1);
      check("ovf_e20", elemOf(20), 100);
      check("ovf_e31", elemOf(31), 111);

      // Zero-length final beats.
      doReset();
      applyStimulus(1, 0, 5, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("zero_valid", out_valid, 1);
      check("zero_len", out_len, 0);
      applyStimulus(1, 40, 2, 3, 1, 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("zero_part_len", out_len, 3);
      check("zero_part_e2", elemOf(2), 44);

      // Reset between halves, then a clean single beat.
      doReset();
      applyStimulus(1, 0, 0, 5, 1, 1);
      doReset();
      applyStimulus(1, 7, 0, 3, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      check("post_rst_len", out_len, 3);
      check("post_rst_e0", elemOf(0), 7);
      check("post_rst_e3", elemOf(3), 0);
      check("post_rst_err", err, 0);

      // Random traffic, mostly legal slices with occasional wild ones.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         int b;
         int l;
         if (i % 500 == 499) begin
            doReset();
         end else begin
            b = $urandom_range(0, 31);
            l = $urandom_range(0, 32 - b);
            if ($urandom_range(0, 19) == 0) begin
               b = $urandom_range(0, 40);
               l = $urandom_range(0, 40);
            end
            applyStimulus($urandom_range(0, 9) < 7, -1, b, l,
                          $urandom_range(0, 1), $urandom_range(0, 9) < 7);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
